// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and fixed-latency access sequencer in front of the bus decoder.
// Optional per-master grant counters are compiled in with `define MEM_BUS_ARB_STATS_EN.
module mem_bus_arbiter #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_BUS_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [31:0]       m0_grant_cnt,
    output logic [31:0]       m1_grant_cnt,
`endif
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                r_grant;
    logic                r_we_l;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr_l;
    logic [DATA_W-1:0]   r_wdata_l;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                w_any_req;
    logic                w_pick;

    // On a tie the master that did not own the bus last time wins.
    assign w_any_req = m0_req | m1_req;
    assign w_pick    = (m0_req && m1_req) ? ~r_last_grant : m1_req;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: read-data registers are architectural outputs, so they are reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we_l       <= 1'b0;
            r_cnt        <= 4'd0;
            r_addr_l     <= '0;
            r_wdata_l    <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_grant   <= w_pick;
                    r_we_l    <= w_pick ? m1_we    : m0_we;
                    r_addr_l  <= w_pick ? m1_addr  : m0_addr;
                    r_wdata_l <= w_pick ? m1_wdata : m0_wdata;
                    r_cnt     <= CNT_LOAD;
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we_l && r_grant)  r_m1_rdata <= bus_rdata;
                        if (!r_we_l && !r_grant) r_m0_rdata <= bus_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE:  r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        unique case (r_state)
            S_ACCESS: begin
                bus_read  = ~r_we_l;
                bus_write = r_we_l;
                bus_addr  = r_addr_l;
                bus_wdata = r_wdata_l;
            end
            S_DONE: begin
                m0_ready = ~r_grant;
                m1_ready = r_grant;
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign grant    = r_grant;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

`ifdef MEM_BUS_ARB_STATS_EN
    logic [31:0] r_m0_cnt;
    logic [31:0] r_m1_cnt;

    // Clear has priority over a coincident DONE increment.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_m0_cnt <= 32'd0;
            r_m1_cnt <= 32'd0;
        end else if (r_state == S_DONE) begin
            if (r_grant) r_m1_cnt <= r_m1_cnt + 32'd1;
            else         r_m0_cnt <= r_m0_cnt + 32'd1;
        end
    end

    assign m0_grant_cnt = r_m0_cnt;
    assign m1_grant_cnt = r_m1_cnt;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_mem_bus_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_ready, m1_ready, bus_read, bus_write, grant, busy;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        stats_clr = 1'b0;
    bit          clr_on_done = 1'b0;
`ifdef MEM_BUS_ARB_STATS_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt;
`endif

    mem_bus_arbiter #(.LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_BUS_ARB_STATS_EN
        .stats_clr(stats_clr), .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt),
`endif
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read),
        .bus_write(bus_write), .bus_rdata(bus_rdata), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is a count of cycles since its grant (0 = idle,
    // 1..LAT = strobes on the bus, LAT+1 = ready cycle).
    int          m_phase = 0;
    bit          m_valid = 1'b0;
    bit          m_owner, m_we, m_last;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rd [2];
    logic [31:0] m_cnt [2];
    bit          on_bus, in_done;

    always @(negedge clk) begin
        on_bus  = (m_phase >= 1) && (m_phase <= LAT);
        in_done = (m_phase == LAT + 1);
        if (m_valid) begin
            check("busy", busy, m_phase != 0);
            if (m_phase != 0) check("grant", grant, m_owner);
            check("bus_read", bus_read, on_bus && !m_we);
            check("bus_write", bus_write, on_bus && m_we);
            if (on_bus) begin
                check("bus_addr", bus_addr, m_addr);
                check("bus_wdata", bus_wdata, m_wdata);
            end else if (m_phase == 0) begin
                check("bus_addr_idle", bus_addr, 32'h0);
                check("bus_wdata_idle", bus_wdata, 32'h0);
            end
            check("m0_ready", m0_ready, in_done && m_owner == 1'b0);
            check("m1_ready", m1_ready, in_done && m_owner == 1'b1);
            check("m0_rdata", m0_rdata, m_rd[0]);
            check("m1_rdata", m1_rdata, m_rd[1]);
`ifdef MEM_BUS_ARB_STATS_EN
            check("m0_grant_cnt", m0_grant_cnt, m_cnt[0]);
            check("m1_grant_cnt", m1_grant_cnt, m_cnt[1]);
`endif
        end
        if (rst) begin
            m_valid = 1'b1;
            m_phase = 0;
            m_last  = 1'b1;
            m_rd[0] = '0; m_rd[1] = '0;
            m_cnt[0] = '0; m_cnt[1] = '0;
        end else if (m_valid) begin
            if (stats_clr) begin
                m_cnt[0] = '0; m_cnt[1] = '0;
            end else if (in_done) begin
                m_cnt[m_owner] = m_cnt[m_owner] + 32'd1;
            end
            if (m_phase == 0) begin
                if (m0_req || m1_req) begin
                    m_owner = (m0_req && m1_req) ? !m_last : m1_req;
                    m_we    = m_owner ? m1_we : m0_we;
                    m_addr  = m_owner ? m1_addr : m0_addr;
                    m_wdata = m_owner ? m1_wdata : m0_wdata;
                    m_phase = 1;
                end
            end else if (m_phase <= LAT) begin
                if (m_phase == LAT && !m_we) m_rd[m_owner] = bus_rdata;
                m_phase++;
            end else begin
                m_last  = m_owner;
                m_phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Issues one access from an IDLE cycle; returns with the DUT back in IDLE.
    task automatic run_access(input bit m, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int cyc,
                              output int wr_cycles, output logic [31:0] seen_wdata);
        bit got = 1'b0;
        if (m) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        cyc = 1; wr_cycles = 0; seen_wdata = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            cyc++;
            if (bus_write) begin wr_cycles++; seen_wdata = bus_wdata; end
            if (m ? m1_ready : m0_ready) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        if (got) stats_clr = clr_on_done;
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        stats_clr = 1'b0;
    endtask

    task automatic wait_ready(output bit who);
        bit got = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (m0_ready || m1_ready) begin got = 1'b1; who = m1_ready; end
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
    endtask

    int          cyc, wrc;
    logic [31:0] seen;
    bit          who;
    bit          tie_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", busy, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_strobes", {bus_read, bus_write}, 32'd0);

        // m0 read: L+2 cycles from request to ready inclusive, data captured.
        bus_rdata = 32'hDEAD_BEEF;
        run_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, cyc, wrc, seen);
        check("m0_read_latency", cyc, 32'd5);
        check("m0_read_data", m0_rdata, 32'hDEAD_BEEF);
        check("m1_rdata_untouched", m1_rdata, 32'h0);

        // m1 write: strobe held LATENCY cycles with the latched data.
        run_access(1'b1, 1'b1, 32'h1000_0000, 32'h0000_00A5, cyc, wrc, seen);
        check("m1_write_cycles", wrc, 32'd3);
        check("m1_write_wdata", seen, 32'h0000_00A5);
        check("m1_rdata_after_write", m1_rdata, 32'h0);
        check("m0_rdata_held", m0_rdata, 32'hDEAD_BEEF);

        // Tie from reset, both held: grants alternate starting with m0.
        do_reset();
        bus_rdata = 32'h1234_5678;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            wait_ready(who);
            check($sformatf("tie_grant_%0d", k), who, tie_exp[k]);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        check("tie_m1_rdata", m1_rdata, 32'h1234_5678);

        // Reset in the 2nd ACCESS cycle of an m1 read.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        step();
        step();
        check("mid_rst_reading", bus_read, 32'd1);
        rst = 1'b1; m1_req = 1'b0;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_strobe", bus_read, 32'd0);
        check("mid_rst_no_ready", m1_ready, 32'd0);
        check("mid_rst_m1_rdata", m1_rdata, 32'h0);
        m0_req = 1'b1; m1_req = 1'b1;
        wait_ready(who);
        check("post_rst_tie_m0", who, 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        step();

`ifdef MEM_BUS_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) run_access(1'b0, 1'b0, 32'h4, 32'h0, cyc, wrc, seen);
        for (int k = 0; k < 3; k++) run_access(1'b1, 1'b1, 32'h8, 32'h1, cyc, wrc, seen);
        check("stats_m0_5", m0_grant_cnt, 32'd5);
        check("stats_m1_3", m1_grant_cnt, 32'd3);
        clr_on_done = 1'b1;
        run_access(1'b0, 1'b0, 32'h4, 32'h0, cyc, wrc, seen);
        clr_on_done = 1'b0;
        check("stats_clr_wins", m0_grant_cnt, 32'd0);
`endif

        // Randomized traffic with occasional resets and counter clears.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 299) == 0);
            stats_clr = ($urandom_range(0, 39) == 0);
            m0_req    = ($urandom_range(0, 3) != 0);
            m1_req    = ($urandom_range(0, 2) != 0);
            m0_we     = $urandom_range(0, 1) == 1;
            m1_we     = $urandom_range(0, 1) == 1;
            m0_addr   = $urandom;
            m1_addr   = $urandom;
            m0_wdata  = $urandom;
            m1_wdata  = $urandom;
            bus_rdata = $urandom;
        end
        rst = 1'b0; stats_clr = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and access sequencer placed in front of the memory/peripheral address decoder.
- Shares the single decoded bus (RAM, LED GPIO, switch GPIO) between master 0 (CPU data port) and master 1 (DMA/debug loader).
- Sequences each access over a fixed read/write latency.
- Returns registered read data with a one-cycle ready pulse.
- Uses round-robin arbitration; a grant is held until its access completes.

Parameters:
- LATENCY, 1, number of cycles bus_read/bus_write are held per access; legal 1..15. Read data is sampled on the last of these cycles.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 access request; held until m0_ready.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_ready  output  1  one-cycle completion pulse to master 0.
- m0_rdata  output  DATA_W  master 0 registered read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata: same as master 0, for master 1.
- bus_addr  output  ADDR_W  address to the decoder.
- bus_wdata  output  DATA_W  write data to the decoder.
- bus_read  output  1  read strobe to the decoder.
- bus_write  output  1  write strobe to the decoder.
- bus_rdata  input  DATA_W  read data from the decoder.
- grant  output  1  index of the owning master; valid while busy.
- busy  output  1  high in ACCESS and DONE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = 1, so master 0 wins the first tie.
  - Wait counter 0; latched request 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE; bus_read = bus_write = 0.
  - Exactly one req: grant it.
  - Both req: grant the master != last_grant.
  - On grant: latch winner's addr, wdata, we into internal registers; set grant; load counter with LATENCY-1; go to ACCESS.
- ACCESS:
  - bus_addr/bus_wdata come from the latched registers and are stable for the whole state.
  - bus_read = !we_l; bus_write = we_l.
  - Counter decrements each cycle.
  - When counter == 0: sample bus_rdata (reads only) into the granted master's rdata register; go to DONE.
  - Duration is exactly LATENCY cycles.
- DONE:
  - Bus strobes deasserted.
  - Granted master's ready = 1 for exactly this cycle.
  - last_grant <= grant; go to IDLE.
- Total access time: LATENCY+2 cycles from req sampled in IDLE to the ready-high cycle inclusive. No arbitration overlap with DONE.
- mX_rdata:
  - Changes only on completion of a read by master X.
  - Holds its value otherwise, including across writes and the other master's accesses.
- Inputs not latched in IDLE are ignored; master address/data changes during ACCESS have no effect.
- Req dropped mid-transaction: the access still completes, strobes run the full LATENCY, and ready still pulses.
- Req held high after ready: treated as a new request in the following IDLE cycle, and arbitrated against the other master.
- bus_addr/bus_wdata drive 0 in IDLE.
- No address-range checking: unmapped addresses complete normally with whatever bus_rdata returns (decoder gives 0).
- Reset mid-operation: state returns to IDLE, strobes drop in the next cycle, no ready is issued, and rdata registers are cleared.

Optional Feature:
- Macro MEM_BUS_ARB_STATS_EN.
- When defined:
  - Adds outputs m0_grant_cnt and m1_grant_cnt, 32 bits each.
  - Each increments by 1 in the DONE cycle of its master, wrapping from 0xFFFF_FFFF to 0.
  - Both clear on rst.
  - Adds input stats_clr (1 bit), a synchronous clear; if stats_clr coincides with an increment, the clear wins.
- When undefined: these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- LATENCY=1, m0 read 0x0000_0100, bus_rdata=0xDEAD_BEEF → bus_read high 1 cycle with bus_addr=0x100; m0_ready pulses 3 cycles after req; m0_rdata=0xDEAD_BEEF; m1_ready stays 0.
- m1 write 0x1000_0000, wdata 0x0000_00A5 → bus_write=1, bus_wdata=0xA5 for LATENCY cycles; m1_ready pulse; m1_rdata unchanged.
- m0_req and m1_req asserted together from reset and held → grants alternate 0,1,0,1; each access takes LATENCY+2 cycles; no cycle has both readys high.
- Only m0 requesting continuously, LATENCY=3 → m0 granted back-to-back; ready every 5 cycles; m1 never granted.
- rst asserted in the 2nd ACCESS cycle of an m1 read (LATENCY=3) → next cycle: IDLE, strobes 0, no m1_ready, m1_rdata=0; next tie goes to m0.
- With MEM_BUS_ARB_STATS_EN, 5 m0 and 3 m1 accesses → counters 5/3; stats_clr pulse coincident with an m0 DONE → m0_grant_cnt=0.
